// File: rtl/ibex_pmp_chk_arb_pkg.sv
// Shared types for the PMP check-channel arbiter: PMP access/privilege encodings
// (ibex_pkg compatible) and the request payload carried through the stage.
package ibex_pmp_chk_arb_pkg;

  localparam int unsigned PMP_ARB_MAX_REQ = 8;
  localparam int unsigned PMP_ADDR_W      = 34;

  typedef enum logic [1:0] {
    PMP_ACC_EXEC  = 2'b00,
    PMP_ACC_WRITE = 2'b01,
    PMP_ACC_READ  = 2'b10
  } pmp_req_e;

  typedef enum logic [1:0] {
    PRIV_LVL_M = 2'b11,
    PRIV_LVL_H = 2'b10,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_U = 2'b00
  } priv_lvl_e;

  typedef struct packed {
    logic [PMP_ADDR_W-1:0] addr;
    pmp_req_e              req_type;
    priv_lvl_e             priv;
  } pmp_chk_req_t;

  function automatic logic [PMP_ARB_MAX_REQ-1:0] idx_to_onehot(input logic [2:0] idx);
    logic [PMP_ARB_MAX_REQ-1:0] oh;
    oh = {{(PMP_ARB_MAX_REQ-1){1'b0}}, 1'b1} << idx;
    return oh;
  endfunction

endpackage

// File: rtl/ibex_pmp_chk_arb_rr_arbiter.sv
// Combinational round-robin arbiter: scans requests starting just after ptr,
// wrapping, and grants the first one found.
module ibex_rr_arbiter #(
  parameter int unsigned N = 3,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] gnt_idx
);

  logic            found;
  logic [IdxW-1:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 1; i <= int'(N); i++) begin
      cand = IdxW'((int'(ptr) + i) % int'(N));
      if (!found && req[cand]) begin
        found       = 1'b1;
        gnt[cand]   = 1'b1;
        gnt_idx     = cand;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/ibex_pmp_chk_arb.sv
// Shares a single ibex_pmp check channel between NumReq requesters: round-robin
// accept, one registered stage driving the PMP, one-cycle tagged response pulse.
module ibex_pmp_chk_arb
  import ibex_pmp_chk_arb_pkg::*;
#(
  parameter int unsigned NumReq       = 3,
  parameter int unsigned SettleCycles = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumReq-1:0]            req_valid_i,
  output logic [NumReq-1:0]            req_ready_o,
  input  logic [NumReq*PMP_ADDR_W-1:0] req_addr_i,
  input  pmp_req_e                     req_type_i [NumReq],
  input  priv_lvl_e                    req_priv_i [NumReq],
  input  logic [NumReq-1:0]            req_kill_i,
  output logic [NumReq-1:0]            rsp_valid_o,
  output logic                         rsp_err_o,
  input  logic                         csr_pmp_wr_i,
  output logic [PMP_ADDR_W-1:0]        pmp_req_addr_o,
  output pmp_req_e                     pmp_req_type_o,
  output priv_lvl_e                    pmp_priv_mode_o,
  input  logic                         pmp_req_err_i
);

  localparam int unsigned IdxW        = $clog2(NumReq);
  localparam logic [1:0]  SETTLE_INIT = 2'(SettleCycles);

  logic [IdxW-1:0]            ptr;
  logic [NumReq-1:0]          gnt;
  logic [IdxW-1:0]            gnt_idx;
  logic                       arb_en;
  logic                       accept;
  logic [1:0]                 settle_cnt;
  logic                       stage_valid;
  logic [IdxW-1:0]            stage_id;
  logic                       stage_kill;
  logic                       rsp_live;
  logic [PMP_ARB_MAX_REQ-1:0] stage_oh;
  pmp_chk_req_t               win_req;

  ibex_rr_arbiter #(.N(NumReq)) u_rr_arbiter (
    .req     (req_valid_i),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // No new accept during reset, the CSR write cycle, or the settle window after it.
  always_comb begin
    arb_en           = !rst_i && !csr_pmp_wr_i && (settle_cnt == 2'd0);
    req_ready_o      = arb_en ? gnt : '0;
    accept           = |(req_valid_i & req_ready_o);
    win_req.addr     = req_addr_i[gnt_idx*PMP_ADDR_W +: PMP_ADDR_W];
    win_req.req_type = req_type_i[gnt_idx];
    win_req.priv     = req_priv_i[gnt_idx];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr             <= IdxW'(NumReq - 1);
      stage_valid     <= 1'b0;
      stage_id        <= '0;
      stage_kill      <= 1'b0;
      pmp_req_addr_o  <= '0;
      pmp_req_type_o  <= PMP_ACC_READ;
      pmp_priv_mode_o <= PRIV_LVL_M;
    end else if (accept) begin
      ptr             <= gnt_idx;
      stage_valid     <= 1'b1;
      stage_id        <= gnt_idx;
      stage_kill      <= req_kill_i[gnt_idx];
      pmp_req_addr_o  <= win_req.addr;
      pmp_req_type_o  <= win_req.req_type;
      pmp_priv_mode_o <= win_req.priv;
    end else begin
      stage_valid     <= 1'b0;
      stage_kill      <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      settle_cnt <= 2'd0;
    end else if (csr_pmp_wr_i) begin
      settle_cnt <= SETTLE_INIT;
    end else if (settle_cnt != 2'd0) begin
      settle_cnt <= settle_cnt - 2'd1;
    end else begin
      settle_cnt <= settle_cnt;
    end
  end

  // A kill seen at accept time or while the stage is owned drops the pulse.
  always_comb begin
    stage_oh    = idx_to_onehot(3'(stage_id));
    rsp_live    = stage_valid && !rst_i && !stage_kill && !req_kill_i[stage_id];
    rsp_valid_o = rsp_live ? stage_oh[NumReq-1:0] : '0;
    rsp_err_o   = rsp_live && pmp_req_err_i;
  end

  ibex_pmp_chk_arb_chk #(.NumReq(NumReq)) u_chk (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .rsp_valid_o (rsp_valid_o)
  );

endmodule

// Protocol checker for the arbiter's handshake and response invariants.
module ibex_pmp_chk_arb_chk #(
  parameter int unsigned NumReq = 3
) (
  input logic              clk_i,
  input logic              rst_i,
  input logic [NumReq-1:0] req_valid_i,
  input logic [NumReq-1:0] req_ready_o,
  input logic [NumReq-1:0] rsp_valid_o
);

  ap_ready_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(req_ready_o));

  ap_rsp_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(rsp_valid_o));

  ap_rsp_after_accept: assert property (@(posedge clk_i) disable iff (rst_i)
    (|rsp_valid_o) |-> $past(|(req_valid_i & req_ready_o)));

endmodule
